// File: rtl/ann_sekvencer_if.sv
// Handshake and shared-neuron bus of the 5-5-2 network sequencer.
// slave = sequencer side, master = sample source / consumer / neuron side.
interface ann_sekvencer_if #(
    parameter int N_IN = 5,
    parameter int W    = 16
);
    logic                clr;
    logic                in_valid;
    logic                in_ready;
    logic [N_IN*W-1:0]   uzorak_in;
    logic [3:0]          neuron_sel;
    logic                layer_sel;
    logic [N_IN*W-1:0]   neuron_in;
    logic [W-1:0]        neuron_out;
    logic                out_valid;
    logic                out_ready;
    logic [W-1:0]        izlaz_0;
    logic [W-1:0]        izlaz_1;
    logic                mina;
    logic                busy;

    modport slave (
        input  clr, in_valid, uzorak_in, neuron_out, out_ready,
        output in_ready, neuron_sel, layer_sel, neuron_in,
               out_valid, izlaz_0, izlaz_1, mina, busy
    );

    modport master (
        output clr, in_valid, uzorak_in, neuron_out, out_ready,
        input  in_ready, neuron_sel, layer_sel, neuron_in,
               out_valid, izlaz_0, izlaz_1, mina, busy
    );
endinterface

// File: rtl/ann_sekvencer.sv
// Time-multiplexes one combinational sigmoid neuron over a 5-5-2 network:
// five hidden slots on the latched sample, then two output slots on the hidden results.
module ann_sekvencer #(
    parameter int N_IN   = 5,
    parameter int N_OUT  = 2,
    parameter int W      = 16,
    parameter int SETTLE = 1
) (
    input logic           clk,
    input logic           rst,
    ann_sekvencer_if.slave bus
);
    localparam int IW = $clog2(N_IN);

    typedef enum logic [1:0] {IDLE, HID, OUT, DONE} state_t;

    state_t                  state_q;
    logic [3:0]              idx_q;
    logic [2:0]              wcnt_q;
    logic [N_IN-1:0][W-1:0]  sample_q;
    logic [N_IN-1:0][W-1:0]  hid_q;
    logic [N_IN-1:0][W-1:0]  hid_d;
    logic [W-1:0]            izlaz_0_q;
    logic [W-1:0]            izlaz_1_q;
    logic                    mina_q;
    logic                    in_ready_q;
    logic                    out_valid_q;
    logic                    busy_q;
    logic                    layer_sel_q;
    logic [3:0]              neuron_sel_q;
    logic [N_IN*W-1:0]       neuron_in_q;
    logic                    slot_end;

    assign slot_end = (wcnt_q == 3'(SETTLE));

    // Hidden vector including the value being captured this edge, so the
    // first output slot already sees the complete operand vector.
    always_comb begin
        hid_d = hid_q;
        hid_d[idx_q[IW-1:0]] = bus.neuron_out;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            wcnt_q       <= '0;
            sample_q     <= '0;
            hid_q        <= '0;
            izlaz_0_q    <= '0;
            izlaz_1_q    <= '0;
            mina_q       <= 1'b0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            layer_sel_q  <= 1'b0;
            neuron_sel_q <= '0;
            neuron_in_q  <= '0;
        end else if (bus.clr) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            wcnt_q       <= '0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            layer_sel_q  <= 1'b0;
            neuron_sel_q <= '0;
            neuron_in_q  <= sample_q;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        state_q      <= HID;
                        sample_q     <= bus.uzorak_in;
                        neuron_in_q  <= bus.uzorak_in;
                        idx_q        <= '0;
                        wcnt_q       <= '0;
                        neuron_sel_q <= '0;
                        layer_sel_q  <= 1'b0;
                        in_ready_q   <= 1'b0;
                        busy_q       <= 1'b1;
                    end
                end
                HID: begin
                    if (!slot_end) begin
                        wcnt_q <= wcnt_q + 3'd1;
                    end else begin
                        wcnt_q <= '0;
                        hid_q  <= hid_d;
                        if (idx_q == 4'(N_IN-1)) begin
                            state_q      <= OUT;
                            idx_q        <= '0;
                            neuron_sel_q <= '0;
                            layer_sel_q  <= 1'b1;
                            neuron_in_q  <= hid_d;
                        end else begin
                            idx_q        <= idx_q + 4'd1;
                            neuron_sel_q <= idx_q + 4'd1;
                        end
                    end
                end
                OUT: begin
                    if (!slot_end) begin
                        wcnt_q <= wcnt_q + 3'd1;
                    end else begin
                        wcnt_q <= '0;
                        if (idx_q == 4'(N_OUT-1)) begin
                            izlaz_1_q    <= bus.neuron_out;
                            mina_q       <= (bus.neuron_out > izlaz_0_q);
                            state_q      <= DONE;
                            out_valid_q  <= 1'b1;
                            busy_q       <= 1'b0;
                            idx_q        <= '0;
                            neuron_sel_q <= '0;
                            layer_sel_q  <= 1'b0;
                            neuron_in_q  <= sample_q;
                        end else begin
                            izlaz_0_q    <= bus.neuron_out;
                            idx_q        <= idx_q + 4'd1;
                            neuron_sel_q <= idx_q + 4'd1;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.busy       = busy_q;
    assign bus.layer_sel  = layer_sel_q;
    assign bus.neuron_sel = neuron_sel_q;
    assign bus.neuron_in  = neuron_in_q;
    assign bus.izlaz_0    = izlaz_0_q;
    assign bus.izlaz_1    = izlaz_1_q;
    assign bus.mina       = mina_q;
endmodule

// File: tb/tb_ann_sekvencer.sv
// Bench for ann_sekvencer: SETTLE=1 and SETTLE=0 instances run side by side on
// shared stimulus, each with its own neuron stub, checked against a network model.
module tb_ann_sekvencer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ann_sekvencer_if #(.N_IN(5), .W(16)) ifa ();
    ann_sekvencer_if #(.N_IN(5), .W(16)) ifb ();

    ann_sekvencer #(.N_IN(5), .N_OUT(2), .W(16), .SETTLE(1)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
    ann_sekvencer #(.N_IN(5), .N_OUT(2), .W(16), .SETTLE(0)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

    int          mode = 0;
    logic [79:0] k0v = '0;
    logic [79:0] k1v = '0;
    int          total = 0;
    int          bad = 0;

    // Neuron stub. Mode 0: 1000 + layer<<8 + sel; mode 1: selected operand word
    // plus a per-neuron key; modes 2/3 override only the output layer.
    function automatic logic [15:0] stub(input int md, input logic [79:0] k0, input logic [79:0] k1,
                                         input logic ls, input logic [3:0] ns, input logic [79:0] nin);
        int s;
        s = (int'(ns) > 4) ? 4 : int'(ns);
        if (md == 1) return nin[s*16 +: 16] + (ls ? k1[s*16 +: 16] : k0[s*16 +: 16]);
        if (ls && md == 2) return 16'h8000;
        if (ls && md == 3) return 16'h0100 - 16'(s);
        return 16'h1000 + {7'd0, ls, 4'd0, ns};
    endfunction

    assign ifa.neuron_out = stub(mode, k0v, k1v, ifa.layer_sel, ifa.neuron_sel, ifa.neuron_in);
    assign ifb.neuron_out = stub(mode, k0v, k1v, ifb.layer_sel, ifb.neuron_sel, ifb.neuron_in);
    assign ifb.clr        = ifa.clr;
    assign ifb.in_valid   = ifa.in_valid;
    assign ifb.uzorak_in  = ifa.uzorak_in;
    assign ifb.out_ready  = ifa.out_ready;

    typedef struct {
        logic [79:0] smp;
        int          mode;
        logic [79:0] k0;
        logic [79:0] k1;
        logic [79:0] nin;
        logic [15:0] iz0;
        logic [15:0] iz1;
        logic        mina;
        int          hold;
    } vec_t;

    vec_t tbl[3];

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Network model: hidden j = word j + k0[j]; output j = hidden j + k1[j].
    function automatic vec_t mk_rand();
        vec_t v;
        logic [15:0] h[5];
        v.smp  = {$urandom, $urandom, $urandom};
        v.k0   = {$urandom, $urandom, $urandom};
        v.k1   = {$urandom, $urandom, $urandom};
        v.mode = 1;
        v.hold = int'($urandom_range(0, 3));
        for (int j = 0; j < 5; j++) h[j] = v.smp[j*16 +: 16] + v.k0[j*16 +: 16];
        v.nin  = {h[4], h[3], h[2], h[1], h[0]};
        v.iz0  = h[0] + v.k1[15:0];
        v.iz1  = h[1] + v.k1[31:16];
        v.mina = (v.iz1 > v.iz0);
        return v;
    endfunction

    task automatic txn(input vec_t v);
        int la, lb;
        logic [79:0] na, nb;
        la = -1; lb = -1; na = '0; nb = '0;
        chk("idle_rdy_a", 80'(ifa.in_ready), 80'(1));
        chk("idle_rdy_b", 80'(ifb.in_ready), 80'(1));
        mode = v.mode; k0v = v.k0; k1v = v.k1;
        ifa.uzorak_in = v.smp;
        ifa.in_valid  = 1'b1;
        step();
        ifa.in_valid = 1'b0;
        for (int n = 1; n <= 40 && (la < 0 || lb < 0); n++) begin
            ifa.uzorak_in = {$urandom, $urandom, $urandom};
            step();
            if (la < 0 && ifa.out_valid) la = n;
            if (lb < 0 && ifb.out_valid) lb = n;
            if (ifa.busy) chk("busy_rdy_a", 80'(ifa.in_ready), 80'(0));
            if (ifa.busy && !ifa.layer_sel) chk("hid_nin_a", ifa.neuron_in, v.smp);
            if (ifa.layer_sel) na = ifa.neuron_in;
            if (ifb.layer_sel) nb = ifb.neuron_in;
        end
        chk("lat_a", 80'(la), 80'(14));
        chk("lat_b", 80'(lb), 80'(7));
        chk("out_nin_a", na, v.nin);
        chk("out_nin_b", nb, v.nin);
        chk("iz0_a", 80'(ifa.izlaz_0), 80'(v.iz0));
        chk("iz1_a", 80'(ifa.izlaz_1), 80'(v.iz1));
        chk("mina_a", 80'(ifa.mina), 80'(v.mina));
        chk("iz0_b", 80'(ifb.izlaz_0), 80'(v.iz0));
        chk("iz1_b", 80'(ifb.izlaz_1), 80'(v.iz1));
        chk("mina_b", 80'(ifb.mina), 80'(v.mina));
        for (int c = 0; c < v.hold; c++) begin
            step();
            chk("hold_vld", 80'({ifa.out_valid, ifb.out_valid, ifa.in_ready}), 80'(3'b110));
            chk("hold_iz", 80'({ifa.izlaz_1, ifa.izlaz_0, ifa.mina}), 80'({v.iz1, v.iz0, v.mina}));
        end
        ifa.out_ready = 1'b1;
        step();
        ifa.out_ready = 1'b0;
        chk("rel_vld", 80'({ifa.out_valid, ifb.out_valid}), 80'(0));
        chk("rel_rdy", 80'({ifa.in_ready, ifb.in_ready}), 80'(2'b11));
    endtask

    initial begin
        vec_t v;
        bit   rose;
        ifa.clr = 1'b0; ifa.in_valid = 1'b0; ifa.out_ready = 1'b0; ifa.uzorak_in = '0;

        tbl[0] = '{80'h0004_0003_0002_0001_0000, 0, '0, '0, 80'h1004_1003_1002_1001_1000,
                   16'h1100, 16'h1101, 1'b1, 0};
        tbl[1] = '{80'h0004_0003_0002_0001_0000, 2, '0, '0, 80'h1004_1003_1002_1001_1000,
                   16'h8000, 16'h8000, 1'b0, 20};
        tbl[2] = '{80'h1234_5678_9abc_def0_0f0f, 3, '0, '0, 80'h1004_1003_1002_1001_1000,
                   16'h0100, 16'h00ff, 1'b0, 2};

        #3 rst = 1'b1;
        #10;
        chk("rst_rdy", 80'({ifa.in_ready, ifb.in_ready}), 80'(2'b11));
        chk("rst_outs", 80'({ifa.out_valid, ifa.busy, ifa.mina, ifa.layer_sel, ifa.neuron_sel}), 80'(0));
        chk("rst_iz", 80'({ifa.izlaz_1, ifa.izlaz_0}), 80'(0));
        chk("rst_nin", ifa.neuron_in, 80'(0));
        #4 rst = 1'b0;
        step();

        for (int i = 0; i < 3; i++) txn(tbl[i]);
        for (int i = 0; i < 6; i++) begin
            v = mk_rand();
            txn(v);
        end

        // clr mid-HID aborts; a fresh sample then runs to completion.
        mode = 0;
        ifa.uzorak_in = tbl[0].smp;
        ifa.in_valid = 1'b1;
        step();
        ifa.in_valid = 1'b0;
        repeat (5) step();
        ifa.clr = 1'b1;
        step();
        ifa.clr = 1'b0;
        chk("clr_state", 80'({ifa.busy, ifa.in_ready, ifa.out_valid, ifb.busy, ifb.in_ready}), 80'(5'b01001));
        rose = 1'b0;
        repeat (20) begin
            step();
            if (ifa.out_valid || ifb.out_valid) rose = 1'b1;
        end
        chk("clr_no_vld", 80'(rose), 80'(0));
        txn(tbl[0]);

        // clr beats in_valid in IDLE.
        ifa.clr = 1'b1; ifa.in_valid = 1'b1;
        step();
        ifa.clr = 1'b0; ifa.in_valid = 1'b0;
        step();
        chk("clr_vs_valid", 80'({ifa.busy, ifa.in_ready, ifb.busy, ifb.in_ready}), 80'(4'b0101));

        // Asynchronous reset mid-OUT.
        ifa.uzorak_in = tbl[0].smp;
        ifa.in_valid = 1'b1;
        step();
        ifa.in_valid = 1'b0;
        repeat (11) step();
        chk("pre_rst_out", 80'({ifa.layer_sel, ifa.busy}), 80'(2'b11));
        #2 rst = 1'b1;
        #1;
        chk("arst_rdy", 80'({ifa.in_ready, ifb.in_ready}), 80'(2'b11));
        chk("arst_outs", 80'({ifa.out_valid, ifa.busy, ifa.mina, ifa.layer_sel, ifa.neuron_sel}), 80'(0));
        chk("arst_iz", 80'({ifa.izlaz_1, ifa.izlaz_0, ifb.izlaz_1, ifb.izlaz_0}), 80'(0));
        chk("arst_nin", ifa.neuron_in | ifb.neuron_in, 80'(0));
        #3 rst = 1'b0;
        step();
        txn(tbl[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ann_sekvencer.md
Name: ann_sekvencer

Overview:
- Sequences one shared, combinational sigmoid neuron evaluator through the full 5-5-2 mine-detection network, one neuron per time slot.
- Accepts one 80-bit sample through a valid/ready handshake and registers it.
- Evaluates the 5 hidden neurons, then the 2 output neurons fed from the stored hidden results.
- Presents both output probabilities and a mine/rock decision through a valid/ready handshake. Sits between the sample source and the shared neuron datapath.

Parameters:
- N_IN, 5, number of 16-bit inputs; also the number of hidden neurons (must be equal).
- N_OUT, 2, number of output neurons (fixed at 2 for the decision logic).
- W, 16, width of the unsigned probability/sample word.
- SETTLE, 1, extra wait cycles per slot for the combinational neuron to settle (0..7).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous abort; returns the block to IDLE.
- in_valid  in  1  sample offered.
- in_ready  out  1  block can accept a sample.
- uzorak_in  in  80  sample; word i occupies [16i+15:16i].
- neuron_sel  out  4  index of the neuron being evaluated.
- layer_sel  out  1  0 = hidden layer, 1 = output layer.
- neuron_in  out  80  operand vector to the shared neuron.
- neuron_out  in  16  probability returned by the shared neuron.
- out_valid  out  1  results available.
- out_ready  in  1  consumer takes the results.
- izlaz_0  out  16  output neuron 0 probability.
- izlaz_1  out  16  output neuron 1 probability.
- mina  out  1  1 when izlaz_1 > izlaz_0 (unsigned compare).
- busy  out  1  high in HID and OUT states.

Behaviour:
- Reset: rst high forces the following asynchronously.
  - State = IDLE; in_ready = 1.
  - out_valid, busy, mina, layer_sel = 0; neuron_sel = 0.
  - izlaz_0, izlaz_1 = 0; sample and hidden registers = 0; neuron_in = 0.
- States: IDLE, HID, OUT, DONE. Registers: idx (4 b), wcnt (3 b), sample (80 b), hid[0..4] (16 b each).
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready: latch uzorak_in into sample; idx = 0, wcnt = 0; go to HID.
  - uzorak_in is ignored at all other times.
- Slots (HID and OUT):
  - Each slot lasts SETTLE+1 cycles.
  - wcnt increments each cycle. At the edge where wcnt == SETTLE, neuron_out is captured and wcnt returns to 0.
- HID:
  - layer_sel = 0, neuron_sel = idx, neuron_in = sample.
  - Capture goes to hid[idx].
  - If idx == N_IN-1: go to OUT with idx = 0. Otherwise idx increments.
- OUT:
  - layer_sel = 1, neuron_sel = idx.
  - neuron_in = {hid[4], hid[3], hid[2], hid[1], hid[0]}, with hid[0] at [15:0].
  - Capture at idx 0 goes to izlaz_0.
  - At idx 1: capture goes to izlaz_1; mina is computed from the captured value against izlaz_0; go to DONE with out_valid = 1.
- Latency: out_valid rises exactly (N_IN+N_OUT)*(SETTLE+1) edges after the accepting edge (14 for the defaults).
- DONE:
  - out_valid = 1; izlaz_0, izlaz_1 and mina are held stable.
  - On out_ready: go to IDLE with out_valid = 0 at that edge; in_ready rises the next cycle.
  - No new sample is accepted in DONE.
- Idle drive: in IDLE and DONE, neuron_sel = 0, layer_sel = 0, neuron_in = sample register.
- in_ready is 0 in HID, OUT and DONE.
- clr:
  - Any state: next state IDLE; out_valid = 0, idx = 0, wcnt = 0.
  - izlaz_0, izlaz_1, mina and hid are unchanged.
  - clr in IDLE together with in_valid: clr wins and no sample is accepted.
- Reset mid-operation: the asynchronous clear described above; the partial results are discarded.
- Arithmetic: no arithmetic on the data path. Values are captured verbatim. mina uses a strict unsigned compare; equal values give mina = 0.

Test Plan:
- Bench stub: neuron_out = 16'h1000 + (layer_sel<<8) + neuron_sel. Drive uzorak_in = 80'h0004_0003_0002_0001_0000 with one in_valid pulse. Required response:
  - hid = 1000..1004.
  - neuron_in in OUT = 80'h1004_1003_1002_1001_1000.
  - izlaz_0 = 16'h1100, izlaz_1 = 16'h1101, mina = 1.
  - out_valid rises 14 cycles after the accepting edge.
- Same stimulus with SETTLE = 0 -> out_valid after 7 cycles, with identical result values.
- Stub returns 16'h8000 for both output neurons -> mina = 0 (equal values). Hold out_ready = 0 for 20 cycles -> out_valid, izlaz_0 and izlaz_1 stay stable. Assert out_ready -> IDLE, with in_ready = 1 on the next cycle.
- Toggle uzorak_in every cycle during HID -> neuron_in stays equal to the latched sample, and in_ready stays 0 throughout.
- Assert clr at cycle 5 of HID -> IDLE the next cycle, out_valid never rises. A new sample then completes normally in 14 cycles.
- Assert rst asynchronously mid-OUT -> all outputs 0 immediately and in_ready = 1. clr and in_valid high together in IDLE -> no acceptance.
